mac_seq: RTL



---
 rtl/mac_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mac_seq.sv
// mac_seq: sequencer for a two-stage multiply-accumulate unit.
// It clears the accumulator, streams len operand addresses with mac_en high,
// drains the pipeline, captures a scaled 32-bit result, then pulses done.
// Optional feature macro: MAC_SEQ_SAT_EN saturates the result and sets ovf
// when accum bits above SHIFT+31 are set.
module mac_seq #(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr,
  output logic              mac_clr,
  output logic              mac_en,
  input  logic [63:0]       accum,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic              ovf
);

  localparam int unsigned HI_SHIFT = SHIFT + 32;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_RUN, S_DRAIN, S_CAPT, S_DONE
  } state_t;

  state_t              state, state_n;
  logic [LEN_W-1:0]    cnt, cnt_n;
  logic [LEN_W-1:0]    len_q, len_n;
  logic [ADDR_W-1:0]   base_q, base_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [31:0]         result_n;
  logic                ovf_n;
  logic                mac_clr_n, mac_en_n, busy_n, done_n;
  logic [31:0]         capt_val_c;
  logic                capt_ovf_c;

  // Scaled capture value, optionally saturated.
  always_comb begin
    capt_val_c = 32'(accum >> SHIFT);
    capt_ovf_c = 1'b0;
`ifdef MAC_SEQ_SAT_EN
    if ((accum >> HI_SHIFT) != 64'd0) begin
      capt_val_c = 32'hFFFF_FFFF;
      capt_ovf_c = 1'b1;
    end
`endif
  end

  // Next-state and next-output decode; outputs follow the next state.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    len_n    = len_q;
    base_n   = base_q;
    addr_n   = addr;
    result_n = result;
    ovf_n    = ovf;

    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_n = S_CLR;
          len_n   = len;
          base_n  = base;
          cnt_n   = '0;
        end
      end
      S_CLR: begin
        cnt_n = '0;
        if (len_q != '0) begin
          state_n = S_RUN;
          addr_n  = base_q;
        end else begin
          state_n = S_DRAIN;
        end
      end
      S_RUN: begin
        if (cnt == LEN_W'(len_q - LEN_W'(1))) begin
          state_n = S_DRAIN;
        end else begin
          cnt_n  = LEN_W'(cnt + LEN_W'(1));
          addr_n = ADDR_W'(addr + ADDR_W'(1));
        end
      end
      S_DRAIN: state_n = S_CAPT;
      S_CAPT: begin
        state_n  = S_DONE;
        result_n = capt_val_c;
        ovf_n    = capt_ovf_c;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Abort wins everywhere except IDLE; result, ovf and addr are kept.
    if (state != S_IDLE && abort) begin
      state_n  = S_IDLE;
      addr_n   = addr;
      result_n = result;
      ovf_n    = ovf;
    end

    mac_clr_n = (state_n == S_CLR);
    mac_en_n  = (state_n == S_RUN);
    busy_n    = (state_n != S_IDLE);
    done_n    = (state_n == S_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      len_q   <= '0;
      base_q  <= '0;
      addr    <= '0;
      mac_clr <= 1'b0;
      mac_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      len_q   <= len_n;
      base_q  <= base_n;
      addr    <= addr_n;
      mac_clr <= mac_clr_n;
      mac_en  <= mac_en_n;
      busy    <= busy_n;
      done    <= done_n;
      result  <= result_n;
      ovf     <= ovf_n;
    end
  end

endmodule
